// File: rtl/ecc_pkg.sv
// Shared ECC definitions: default coordinate width, scalar-multiply FSM states
// and the bit-index width helper.
`ifndef MAX_BITS
`define MAX_BITS 8
`endif

package ecc_pkg;

  localparam int unsigned MAX_BITS = `MAX_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DBL      = 3'd1,
    DBL_WAIT = 3'd2,
    ADD      = 3'd3,
    ADD_WAIT = 3'd4,
    NEXT     = 3'd5,
    DONE     = 3'd6
  } smul_state_e;

  // Width of a bit index into a W-bit scalar (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*G over an external point unit.
// Optional macro SMUL_OP_COUNT_EN adds a saturating o_op_count of issued operations.
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned W = `MAX_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_k,
  input  logic [W-1:0] i_gx,
  input  logic [W-1:0] i_gy,
  output logic         o_busy,
  output logic         o_finish,
  output logic [W-1:0] o_result_x,
  output logic [W-1:0] o_result_y,
  output logic         o_inf,
  output logic         o_po_add_start,
  output logic         o_po_double_start,
  output logic [W-1:0] o_po_x1,
  output logic [W-1:0] o_po_y1,
  output logic [W-1:0] o_po_x2,
  output logic [W-1:0] o_po_y2,
  input  logic         i_po_finish,
  input  logic [W-1:0] i_po_x,
  input  logic [W-1:0] i_po_y
`ifdef SMUL_OP_COUNT_EN
  ,
  output logic [15:0]  o_op_count
`endif
);

  localparam int unsigned IW = idx_width(W);

  smul_state_e r_state, w_state;
  logic [W-1:0]  r_rx, w_rx, r_ry, w_ry;
  logic          r_inf, w_inf;
  logic [W-1:0]  r_gx, w_gx, r_gy, w_gy;
  logic [W-1:0]  r_k, w_k;
  logic [IW-1:0] r_idx, w_idx;
  logic [W-1:0]  r_x1, w_x1, r_y1, w_y1, r_x2, w_x2, r_y2, w_y2;
  logic          r_add_st, w_add_st, r_dbl_st, w_dbl_st;
  logic          r_busy, w_busy, r_finish, w_finish;
  logic [W-1:0]  r_res_x, w_res_x, r_res_y, w_res_y;
  logic          r_out_inf, w_out_inf;

  // Next-state and next-register computation.
  always_comb begin
    w_state   = r_state;
    w_rx      = r_rx;
    w_ry      = r_ry;
    w_inf     = r_inf;
    w_gx      = r_gx;
    w_gy      = r_gy;
    w_k       = r_k;
    w_idx     = r_idx;
    w_x1      = r_x1;
    w_y1      = r_y1;
    w_x2      = r_x2;
    w_y2      = r_y2;
    w_add_st  = 1'b0;
    w_dbl_st  = 1'b0;
    w_busy    = r_busy;
    w_finish  = 1'b0;
    w_res_x   = r_res_x;
    w_res_y   = r_res_y;
    w_out_inf = r_out_inf;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_k     = i_k;
          w_gx    = i_gx;
          w_gy    = i_gy;
          w_inf   = 1'b1;
          w_idx   = IW'(W - 1);
          w_busy  = 1'b1;
          w_state = DBL;
        end
      end
      DBL: begin
        if (r_inf) begin
          w_state = ADD;
        end else if (r_ry == '0) begin
          // Doubling a point with y = 0 gives infinity; the point unit cannot.
          w_inf   = 1'b1;
          w_state = ADD;
        end else begin
          w_x1     = r_rx;
          w_y1     = r_ry;
          w_x2     = r_rx;
          w_y2     = r_ry;
          w_dbl_st = 1'b1;
          w_state  = DBL_WAIT;
        end
      end
      DBL_WAIT: begin
        if (i_po_finish) begin
          w_rx    = i_po_x;
          w_ry    = i_po_y;
          w_state = ADD;
        end
      end
      ADD: begin
        if (!r_k[r_idx]) begin
          w_state = NEXT;
        end else if (r_inf) begin
          w_rx    = r_gx;
          w_ry    = r_gy;
          w_inf   = 1'b0;
          w_state = NEXT;
        end else if (r_rx == r_gx && r_ry == r_gy) begin
          w_x1     = r_gx;
          w_y1     = r_gy;
          w_x2     = r_gx;
          w_y2     = r_gy;
          w_dbl_st = 1'b1;
          w_state  = ADD_WAIT;
        end else if (r_rx == r_gx) begin
          // R == -G: sum is infinity.
          w_inf   = 1'b1;
          w_state = NEXT;
        end else begin
          w_x1     = r_rx;
          w_y1     = r_ry;
          w_x2     = r_gx;
          w_y2     = r_gy;
          w_add_st = 1'b1;
          w_state  = ADD_WAIT;
        end
      end
      ADD_WAIT: begin
        if (i_po_finish) begin
          w_rx    = i_po_x;
          w_ry    = i_po_y;
          w_state = NEXT;
        end
      end
      NEXT: begin
        if (r_idx == '0) begin
          w_res_x   = r_inf ? '0 : r_rx;
          w_res_y   = r_inf ? '0 : r_ry;
          w_out_inf = r_inf;
          w_finish  = 1'b1;
          w_busy    = 1'b0;
          w_state   = DONE;
        end else begin
          w_idx   = r_idx - IW'(1);
          w_state = DBL;
        end
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rx      <= '0;
      r_ry      <= '0;
      r_inf     <= 1'b1;
      r_gx      <= '0;
      r_gy      <= '0;
      r_k       <= '0;
      r_idx     <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_x2      <= '0;
      r_y2      <= '0;
      r_add_st  <= 1'b0;
      r_dbl_st  <= 1'b0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_res_x   <= '0;
      r_res_y   <= '0;
      r_out_inf <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_rx      <= w_rx;
      r_ry      <= w_ry;
      r_inf     <= w_inf;
      r_gx      <= w_gx;
      r_gy      <= w_gy;
      r_k       <= w_k;
      r_idx     <= w_idx;
      r_x1      <= w_x1;
      r_y1      <= w_y1;
      r_x2      <= w_x2;
      r_y2      <= w_y2;
      r_add_st  <= w_add_st;
      r_dbl_st  <= w_dbl_st;
      r_busy    <= w_busy;
      r_finish  <= w_finish;
      r_res_x   <= w_res_x;
      r_res_y   <= w_res_y;
      r_out_inf <= w_out_inf;
    end
  end

`ifdef SMUL_OP_COUNT_EN
  logic [15:0] r_op_count;

  // Saturating count of issued point operations, cleared on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op_count <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_op_count <= '0;
    end else if ((w_add_st || w_dbl_st) && r_op_count != 16'hFFFF) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign o_op_count = r_op_count;
`endif

  assign o_busy            = r_busy;
  assign o_finish          = r_finish;
  assign o_result_x        = r_res_x;
  assign o_result_y        = r_res_y;
  assign o_inf             = r_out_inf;
  assign o_po_add_start    = r_add_st;
  assign o_po_double_start = r_dbl_st;
  assign o_po_x1           = r_x1;
  assign o_po_y1           = r_y1;
  assign o_po_x2           = r_x2;
  assign o_po_y2           = r_y2;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17, G = (5, 1).
module tb_scalar_mult_ctrl;

  localparam int unsigned W    = 8;
  localparam int          MAXC = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [W-1:0] i_k, i_gx, i_gy;
  logic         o_busy, o_finish, o_inf;
  logic [W-1:0] o_result_x, o_result_y;
  logic         o_po_add_start, o_po_double_start;
  logic [W-1:0] o_po_x1, o_po_y1, o_po_x2, o_po_y2;
  logic         po_finish;
  logic [W-1:0] po_x, po_y;
`ifdef SMUL_OP_COUNT_EN
  logic [15:0]  o_op_count;
`endif

  int errors = 0;
  int checks = 0;

  scalar_mult_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_k(i_k), .i_gx(i_gx), .i_gy(i_gy),
    .o_busy(o_busy), .o_finish(o_finish), .o_result_x(o_result_x), .o_result_y(o_result_y),
    .o_inf(o_inf), .o_po_add_start(o_po_add_start), .o_po_double_start(o_po_double_start),
    .o_po_x1(o_po_x1), .o_po_y1(o_po_y1), .o_po_x2(o_po_x2), .o_po_y2(o_po_y2),
    .i_po_finish(po_finish), .i_po_x(po_x), .i_po_y(po_y)
`ifdef SMUL_OP_COUNT_EN
    , .o_op_count(o_op_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int md(input int a);
    return ((a % 17) + 17) % 17;
  endfunction

  function automatic int inv(input int a);
    int r;
    r = 0;
    for (int i = 1; i < 17; i++) if (md(a * i) == 1) r = i;
    return r;
  endfunction

  // Behavioural point unit with programmable latency.
  int latency = 1;
  int cnt_m   = 0;
  bit busy_m  = 0;
  int res_x, res_y;
  int n_add = 0, n_dbl = 0, viol = 0;
  logic prev_add = 0, prev_dbl = 0;

  always @(posedge clk) begin
    int lam, x1, y1, x2, y2, xr;
    po_finish <= 1'b0;
    if (!rst) begin
      busy_m   <= 0;
      cnt_m    <= 0;
      prev_add <= 0;
      prev_dbl <= 0;
    end else begin
      prev_add <= o_po_add_start;
      prev_dbl <= o_po_double_start;
      if ((o_po_add_start && prev_add) || (o_po_double_start && prev_dbl) ||
          (o_po_add_start && o_po_double_start)) viol <= viol + 1;
      if (o_po_add_start || o_po_double_start) begin
        if (busy_m) viol <= viol + 1;
        x1 = int'(o_po_x1); y1 = int'(o_po_y1); x2 = int'(o_po_x2); y2 = int'(o_po_y2);
        if (o_po_double_start) begin
          lam = md((3 * x1 * x1 + 2) * inv(md(2 * y1)));
          n_dbl <= n_dbl + 1;
        end else begin
          lam = md(md(y2 - y1) * inv(md(x2 - x1)));
          n_add <= n_add + 1;
        end
        xr    = md(lam * lam - x1 - x2);
        res_x <= xr;
        res_y <= md(lam * (x1 - xr) - y1);
        cnt_m  <= latency;
        busy_m <= 1;
      end else if (busy_m) begin
        if (cnt_m <= 1) begin
          po_finish <= 1'b1;
          po_x      <= W'(res_x);
          po_y      <= W'(res_y);
          busy_m    <= 0;
        end else begin
          cnt_m <= cnt_m - 1;
        end
      end
    end
  end

  // Starts a run and waits (bounded) for o_finish; cyc counts cycles after accept.
  task automatic run_mult(input logic [W-1:0] k, input int lat, output int cyc, output bit to,
                          output int adds, output int dbls);
    int a0, d0;
    latency = lat;
    @(negedge clk);
    a0 = n_add; d0 = n_dbl;
    i_k = k; i_gx = W'(5); i_gy = W'(1); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    while (o_finish !== 1'b1 && cyc < MAXC) begin
      @(negedge clk);
      cyc++;
    end
    to   = (o_finish !== 1'b1);
    adds = n_add - a0;
    dbls = n_dbl - d0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_start = 1'b0; i_k = '0; i_gx = '0; i_gy = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_finish, o_inf, o_po_add_start, o_po_double_start} !== 5'b0 ||
        {o_result_x, o_result_y, o_po_x1, o_po_y1, o_po_x2, o_po_y2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b fin=%b inf=%b rx=%0d ry=%0d, want all 0",
               o_busy, o_finish, o_inf, o_result_x, o_result_y);
    end
    rst = 1'b1;
  endtask

  task automatic test_k0();
    int cyc, a, d; bit to;
    run_mult(W'(0), 2, cyc, to, a, d);
    checks++;
    if (to || cyc !== 3 * W + 1) begin
      errors++; $display("FAIL k0_latency: got %0d (timeout=%0b), want %0d", cyc, to, 3 * W + 1);
    end
    checks++;
    if ({o_inf, o_result_x, o_result_y} !== {1'b1, W'(0), W'(0)}) begin
      errors++; $display("FAIL k0_result: got inf=%b (%0d,%0d), want inf=1 (0,0)", o_inf, o_result_x, o_result_y);
    end
    checks++;
    if (a + d !== 0) begin
      errors++; $display("FAIL k0_ops: got %0d ops, want 0", a + d);
    end
    @(negedge clk);
    checks++;
    if (o_finish !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL k0_pulse: got finish=%b busy=%b, want 0 0", o_finish, o_busy);
    end
  endtask

  task automatic test_point(input string nm, input logic [W-1:0] k, input int lat,
                            input bit e_inf, input int ex, input int ey,
                            input int e_add, input int e_dbl);
    int cyc, a, d; bit to;
    run_mult(k, lat, cyc, to, a, d);
    checks++;
    if (to) begin
      errors++; $display("FAIL %s_timeout: got no finish after %0d cycles, want finish", nm, cyc);
    end
    checks++;
    if ({o_inf, o_result_x, o_result_y} !== {e_inf, W'(ex), W'(ey)} || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got inf=%b (%0d,%0d) busy=%b, want inf=%b (%0d,%0d) busy=0",
               nm, o_inf, o_result_x, o_result_y, o_busy, e_inf, ex, ey);
    end
    checks++;
    if (a !== e_add || d !== e_dbl) begin
      errors++; $display("FAIL %s_ops: got add=%0d dbl=%0d, want add=%0d dbl=%0d", nm, a, d, e_add, e_dbl);
    end
`ifdef SMUL_OP_COUNT_EN
    checks++;
    if (o_op_count !== 16'(e_add + e_dbl)) begin
      errors++; $display("FAIL %s_op_count: got %0d, want %0d", nm, o_op_count, e_add + e_dbl);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({o_inf, o_result_x, o_result_y} !== {e_inf, W'(ex), W'(ey)}) begin
      errors++; $display("FAIL %s_hold: got inf=%b (%0d,%0d), want held result", nm, o_inf, o_result_x, o_result_y);
    end
  endtask

  task automatic test_abort_restart();
    int n; bit seen;
    latency = 6;
    @(negedge clk);
    i_k = W'(9); i_gx = W'(5); i_gy = W'(1); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_k = W'(1); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_finish !== 1'b0) begin
      errors++; $display("FAIL restart_ignored: got busy=%b finish=%b, want 1 0", o_busy, o_finish);
    end
    seen = 0; n = 0;
    while (!seen && n < MAXC) begin
      if (o_po_double_start === 1'b1) seen = 1;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL abort_dbl_issue: got no double_start, want one");
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({o_busy, o_finish, o_inf, o_po_add_start, o_po_double_start} !== 5'b0 ||
        {o_result_x, o_result_y, o_po_x1, o_po_y1, o_po_x2, o_po_y2} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b inf=%b x1=%0d y1=%0d, want all 0",
               o_busy, o_inf, o_po_x1, o_po_y1);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_po_double_start !== 1'b0 || o_po_add_start !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b, want 0", o_busy);
    end
    test_point("k9_after_reset", W'(9), 3, 1'b0, 7, 6, 1, 3);
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL start_protocol: got %0d violations, want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_k0();
    test_point("k1", W'(1), 2, 1'b0, 5, 1, 0, 0);
    test_point("k3", W'(3), 1, 1'b0, 10, 6, 1, 1);
    test_point("k5", W'(5), 4, 1'b0, 9, 16, 1, 2);
    test_point("k19", W'(19), 3, 1'b1, 0, 0, 1, 4);
    test_point("k9", W'(9), 1, 1'b0, 7, 6, 1, 3);
    test_abort_restart();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
